// File: rtl/rf_wb_queue.sv
// Writeback queue/arbiter in front of the register-file write port. The main pipe always wins,
// and long-latency results are queued. Optional bypass feature: RF_WBQ_BYPASS_EN.
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       pipe_wena,
    input  logic [4:0]                 pipe_waddr,
    input  logic [31:0]                pipe_wdata,
    input  logic                       mc_valid,
    output logic                       mc_ready,
    input  logic [4:0]                 mc_waddr,
    input  logic [31:0]                mc_wdata,
    output logic                       RF_Wena,
    output logic [4:0]                 w_addr,
    output logic [31:0]                w_data,
    input  logic [4:0]                 r_addr1,
    input  logic [4:0]                 r_addr2,
    output logic                       hazard1,
    output logic                       hazard2,
    output logic                       fwd_valid1,
    output logic                       fwd_valid2,
    output logic [31:0]                fwd_data1,
    output logic [31:0]                fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic          wena_q;
    logic [4:0]    addr_q;
    logic [31:0]   data_q;

    logic pipe_wr, store, pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign mc_ready = ena & ~full;
    assign RF_Wena  = ena & wena_q;
    assign w_addr   = addr_q;
    assign w_data   = data_q;

    assign pipe_wr = pipe_wena & (pipe_waddr != 5'd0);
    // A same-cycle pipe write to the same register is younger, so the mc result is dropped.
    assign store   = mc_valid & mc_ready & (mc_waddr != 5'd0)
                   & ~(pipe_wena & (pipe_waddr == mc_waddr));
    assign pop     = ena & ~pipe_wr & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            wena_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (ena) begin
            if (pipe_wr) begin
                wena_q <= 1'b1;
                addr_q <= pipe_waddr;
                data_q <= pipe_wdata;
                // Kill older queued writes to this register so they cannot land afterwards.
                for (int i = 0; i < DEPTH; i++)
                    if (q[i].addr == pipe_waddr) q[i].live <= 1'b0;
            end else if (pop) begin
                wena_q        <= q[head].live;
                addr_q        <= q[head].addr;
                data_q        <= q[head].data;
                q[head].live  <= 1'b0;
                head          <= head + PW'(1);
            end else begin
                wena_q <= 1'b0;
            end
            if (store) begin
                q[tail] <= '{live: 1'b1, addr: mc_waddr, data: mc_wdata};
                tail    <= tail + PW'(1);
            end
            if (store && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !store) cnt <= cnt - CW'(1);
        end
    end

    // Live bits are only ever set on occupied slots, so scanning all slots is enough.
    logic [1:0][4:0] raddr;
    logic [1:0]      raw;
    assign raddr = {r_addr2, r_addr1};

`ifdef RF_WBQ_BYPASS_EN
    logic [1:0][31:0] fdata;
`endif

    for (genvar p = 0; p < 2; p++) begin : g_port
        always_comb begin
            logic qhit;
            qhit = 1'b0;
`ifdef RF_WBQ_BYPASS_EN
            fdata[p] = data_q;
`endif
            // Oldest to newest, so the last match is the one nearest the tail.
            for (int k = 0; k < DEPTH; k++) begin
                if (q[head + PW'(k)].live && q[head + PW'(k)].addr == raddr[p]) begin
                    qhit = 1'b1;
`ifdef RF_WBQ_BYPASS_EN
                    fdata[p] = q[head + PW'(k)].data;
`endif
                end
            end
            raw[p] = (raddr[p] != 5'd0) & (qhit | (RF_Wena & (addr_q == raddr[p])));
        end
    end

`ifdef RF_WBQ_BYPASS_EN
    assign hazard1    = 1'b0;
    assign hazard2    = 1'b0;
    assign fwd_valid1 = raw[0];
    assign fwd_valid2 = raw[1];
    assign fwd_data1  = raw[0] ? fdata[0] : 32'd0;
    assign fwd_data2  = raw[1] ? fdata[1] : 32'd0;
`else
    assign hazard1    = raw[0];
    assign hazard2    = raw[1];
    assign fwd_valid1 = 1'b0;
    assign fwd_valid2 = 1'b0;
    assign fwd_data1  = 32'd0;
    assign fwd_data2  = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue (default DEPTH=4, either bypass build).
module tb_rf_wb_queue;
    logic        clk = 1'b0;
    logic        rst_n, ena;
    logic        pipe_wena, mc_valid, mc_ready;
    logic [4:0]  pipe_waddr, mc_waddr, w_addr, r_addr1, r_addr2;
    logic [31:0] pipe_wdata, mc_wdata, w_data, fwd_data1, fwd_data2;
    logic        RF_Wena, hazard1, hazard2, fwd_valid1, fwd_valid2, full, empty;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .pipe_wena(pipe_wena), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
        .RF_Wena(RF_Wena), .w_addr(w_addr), .w_data(w_data),
        .r_addr1(r_addr1), .r_addr2(r_addr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(RF_Wena), 32'(we));
        if (we) begin
            chk({tag, "_addr"}, 32'(w_addr), 32'(a));
            chk({tag, "_data"}, w_data, d);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        pipe_wena = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
        r_addr1 = '0; r_addr2 = '0;
        #2;
        chk("rst_wena",  32'(RF_Wena), 0);
        chk("rst_waddr", 32'(w_addr), 0);
        chk("rst_wdata", w_data, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        rst_n = 1'b1;
        tick();

        // plain pipe write, then r0 write is ignored
        pipe_wena = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h0000_1234;
        tick();
        wr("pipe_r5", 1'b1, 5'd5, 32'h0000_1234);
        pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD_BEEF;
        tick();
        wr("pipe_r0", 1'b0, 5'd0, 32'd0);
        chk("pipe_r0_hold", 32'(w_addr), 5);

        // fill the queue while the pipe holds the port
        pipe_waddr = 5'd1; pipe_wdata = 32'h11;
        for (int i = 2; i <= 5; i++) begin
            mc_valid = 1'b1; mc_waddr = 5'(i); mc_wdata = 32'hA0 + 32'(i);
            tick();
        end
        mc_valid = 1'b0;
        #1;
        chk("fill_count", 32'(count), 4);
        chk("fill_full",  32'(full), 1);
        chk("fill_ready", 32'(mc_ready), 0);
        wr("fill_pipe", 1'b1, 5'd1, 32'h11);

        // drop the pipe: r2..r5 drain in order
        pipe_wena = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            wr($sformatf("drain_r%0d", i), 1'b1, 5'(i), 32'hA0 + 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);
        tick();
        chk("drain_idle", 32'(RF_Wena), 0);

        // refill, start draining, reset at count=3
        pipe_wena = 1'b1; pipe_waddr = 5'd1;
        for (int i = 2; i <= 5; i++) begin
            mc_valid = 1'b1; mc_waddr = 5'(i); mc_wdata = 32'hB0 + 32'(i);
            tick();
        end
        mc_valid = 1'b0; pipe_wena = 1'b0;
        tick();
        chk("mid_count", 32'(count), 3);
        wr("mid_r2", 1'b1, 5'd2, 32'hB2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_wena",  32'(RF_Wena), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", 32'(mc_ready), 1);
        tick();
        chk("arst_noold", 32'(RF_Wena), 0);

        // kill: r7 queued behind blocked head, then pipe writes r7
        pipe_wena = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h11;
        mc_valid = 1'b1; mc_waddr = 5'd7; mc_wdata = 32'hAAAA;
        tick();
        mc_valid = 1'b0;
        chk("kill_q", 32'(count), 1);
        pipe_waddr = 5'd7; pipe_wdata = 32'hBBBB;
        tick();
        wr("kill_pipe", 1'b1, 5'd7, 32'hBBBB);
        pipe_wena = 1'b0;
        tick();
        chk("kill_noop", 32'(RF_Wena), 0);
        chk("kill_count", 32'(count), 0);

        // hazard / bypass on live queued r9 and output-stage r1
        pipe_wena = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h11;
        mc_valid = 1'b1; mc_waddr = 5'd9; mc_wdata = 32'h55;
        tick();
        mc_valid = 1'b0;
        r_addr1 = 5'd9; r_addr2 = 5'd0;
        #1;
`ifdef RF_WBQ_BYPASS_EN
        chk("byp_valid1", 32'(fwd_valid1), 1);
        chk("byp_data1",  fwd_data1, 32'h55);
        chk("byp_haz1",   32'(hazard1), 0);
        chk("byp_valid2", 32'(fwd_valid2), 0);
`else
        chk("haz1", 32'(hazard1), 1);
        chk("haz2", 32'(hazard2), 0);
        chk("nobyp_valid1", 32'(fwd_valid1), 0);
`endif
        r_addr2 = 5'd1;
        #1;
`ifdef RF_WBQ_BYPASS_EN
        chk("byp_stage_v", 32'(fwd_valid2), 1);
        chk("byp_stage_d", fwd_data2, 32'h11);
`else
        chk("haz_stage", 32'(hazard2), 1);
`endif
        r_addr1 = 5'd0; r_addr2 = 5'd0;
        pipe_wena = 1'b0;
        tick();
        wr("haz_drain", 1'b1, 5'd9, 32'h55);
        chk("haz_empty", 32'(empty), 1);

        // same-cycle pipe and mc to r3
        pipe_wena = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h333;
        mc_valid = 1'b1; mc_waddr = 5'd3; mc_wdata = 32'hC3;
        tick();
        wr("same_pipe", 1'b1, 5'd3, 32'h333);
        chk("same_count", 32'(count), 0);
        pipe_wena = 1'b0; mc_valid = 1'b0;
        tick();
        chk("same_nomc", 32'(RF_Wena), 0);

        // mc to r0: accepted, not stored
        mc_valid = 1'b1; mc_waddr = 5'd0; mc_wdata = 32'hEE;
        #1;
        chk("r0_ready", 32'(mc_ready), 1);
        tick();
        mc_valid = 1'b0;
        chk("r0_count", 32'(count), 0);

        // ena low freezes everything and gates RF_Wena
        pipe_wena = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h11;
        mc_valid = 1'b1; mc_waddr = 5'd10; mc_wdata = 32'hAB;
        tick();
        pipe_wena = 1'b0; mc_valid = 1'b0; ena = 1'b0;
        #1;
        chk("ena_wena",  32'(RF_Wena), 0);
        chk("ena_ready", 32'(mc_ready), 0);
        tick();
        chk("ena_count", 32'(count), 1);
        ena = 1'b1;
        #1;
        chk("ena_resume_stage", 32'(RF_Wena), 1);
        tick();
        wr("ena_pop", 1'b1, 5'd10, 32'hAB);
        chk("ena_empty", 32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Writeback queue and arbiter in front of the MIPS register file's single write port. Merges the always-accepted main-pipeline writeback with results from long-latency units (divider, multicycle load) over a valid/ready handshake, buffering the latter in a small FIFO. It drives `RF_Wena`/`w_addr`/`w_data` of the register file from a registered output stage. It also reports read-after-write hazards on the two decode read addresses against pending writes.

## Interface
- `DEPTH`, 4, FIFO entries for long-latency results; power of two, ≥2
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  global enable; low = all state frozen, `RF_Wena` forced 0, `mc_ready` 0
- `pipe_wena`  in  1  main-pipeline writeback request; never back-pressured
- `pipe_waddr`  in  5  destination register of pipeline writeback
- `pipe_wdata`  in  32  pipeline writeback data
- `mc_valid`  in  1  long-latency result valid
- `mc_ready`  out  1  `ena & !full`, combinational
- `mc_waddr`  in  5  long-latency destination register
- `mc_wdata`  in  32  long-latency result data
- `RF_Wena`  out  1  registered write enable to register file
- `w_addr`  out  5  registered write address
- `w_data`  out  32  registered write data
- `r_addr1`, `r_addr2`  in  5 each  decode read addresses
- `hazard1`, `hazard2`  out  1 each  combinational stall request per read port
- `fwd_valid1`, `fwd_valid2`  out  1 each  bypass hit (only with `RF_WBQ_BYPASS_EN`)
- `fwd_data1`, `fwd_data2`  out  32 each  bypass data (only with `RF_WBQ_BYPASS_EN`)
- `count`  out  $clog2(DEPTH+1)  occupied FIFO slots, live or killed
- `full`, `empty`  out  1 each  `count==DEPTH`, `count==0`

## Operation
- FIFO entry: {live, addr[4:0], data[31:0]}; head/tail pointers wrap modulo DEPTH.
- Enqueue on `mc_valid & mc_ready`. `mc_waddr==0` accepted but not stored. If `pipe_wena` asserts the same cycle with `pipe_waddr==mc_waddr`, the mc result is older: accepted and discarded.
- Pipe write (`pipe_wena & pipe_waddr!=0`): loads the output stage, sets `RF_Wena`=1. Clears `live` on every queued entry with the same addr (kill), so no stale write lands afterwards.
- Otherwise, if `!empty`, pop head into the output stage. `RF_Wena`=head.live. A killed entry drains as a no-op cycle.
- Otherwise `RF_Wena`=0; `w_addr`/`w_data` hold.
- `pipe_waddr==0`: treated as no pipe write; the queue may drain.
- Count: +1 on store, −1 on pop, unchanged when both or neither occur.
- Hazard: `hazardN` = `r_addrN!=0` & (a live queue entry matches, or `RF_Wena & w_addr==r_addrN`). The output-stage match is included because the register file commits at the next edge.

## Timing
- Reset (`rst_n` low, any time, including mid-drain): `RF_Wena`=0, `w_addr`=0, `w_data`=0, count=0, `empty`=1, `full`=0, pointers 0, all entries dead, `fwd_validN`=0. Queued results are lost.
- Pipe write to output stage: 1 cycle. Register file commits at the following edge.
- mc result stored at edge N reaches the output stage no earlier than edge N+1, and only in a cycle with no pipe write.
- Full: `mc_ready`=0. No enqueue even if a pop occurs that cycle.
- `ena` low: pointers, entries, count and the output stage hold. `RF_Wena` reads 0.

## Configuration
- `RF_WBQ_BYPASS_EN` defined:
  - `fwd_validN`=1 when `hazardN` would be 1.
  - `fwd_dataN` = data of the newest live queue match (nearest tail), else output-stage data.
  - `hazardN` forced 0.
- Undefined: bypass ports tied to 0. Decode stalls on `hazardN`.

## Test plan
- Assert `rst_n`=0 mid-drain with count=3 → immediately `RF_Wena`=0, count=0, `empty`=1, `mc_ready`=1 after release with `ena`=1.
- Pipe write r5=0x00001234 → next cycle `RF_Wena`=1, `w_addr`=5, `w_data`=0x00001234; r0 write → `RF_Wena`=0.
- Hold `pipe_wena` on r1, push mc r2..r5 (0xA2..0xA5) → `full`=1, `mc_ready`=0. Drop `pipe_wena` → four consecutive writes r2..r5 in order, then `empty`=1.
- Queue r7=0xAAAA behind a blocked head, then pipe writes r7=0xBBBB → one write of 0xBBBB, the r7 slot drains with `RF_Wena`=0, `count` decrements.
- Queued live r9=0x55, `r_addr1`=9, `r_addr2`=0:
  - macro off → `hazard1`=1, `hazard2`=0.
  - macro on → `fwd_valid1`=1, `fwd_data1`=0x55, `hazard1`=0.
- Same-cycle pipe and mc both to r3 → only the pipe data is written; count unchanged.
